moltiplicatore_seq: RTL and testbench

- Iterative shift-and-add unsigned multiplier; one multiplier bit per clock.
- Sits directly upstream of the 32-bit write-enabled register in the datapath.
- prod_lo drives the register's data input; the one-cycle done pulse drives its write enable, so the product is written exactly once per operation.
- prod_hi is available for a second register, e.g. a HI register.

---
 rtl/moltiplicatore_seq.sv | 93 +++++++++
 tb/tb_moltiplicatore_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/moltiplicatore_seq.sv
// Iterative shift-and-add unsigned multiplier, one multiplier bit per clock.
// An operation accepted on edge E0 iterates on edges E1..EN. The 2N-bit
// product appears on {prod_hi, prod_lo} at EN, and done pulses for the
// following cycle so a downstream register can write prod_lo exactly once.
module moltiplicatore_seq #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] prod_lo,
    output logic [N-1:0] prod_hi
);

    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     r_state;
    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_mplier;
    logic [2*N-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_prod;

    logic [2*N-1:0] w_sum;
    logic           w_last;

    // Partial sum for this iteration: add the shifted multiplicand when the current multiplier bit is set.
    // NOTE: assign a default before any conditional update so the block stays purely combinational (no latch).
    always_comb begin
        w_sum = r_acc;
        if (r_mplier[0]) begin
            w_sum = r_acc + r_mcand;
        end
    end

    // The Nth iteration is the one that starts with the counter at N-1.
    assign w_last = (r_cnt == CW'(N - 1));

    // Control FSM and datapath registers. A start seen in RUN is ignored; in IDLE or DONE it loads new operands.
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_prod   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_mcand  <= {{N{1'b0}}, a};
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_prod  <= w_sum;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Status and product outputs are decoded straight from registers, so reset clears them without a clock.
    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign prod_lo = r_prod[N-1:0];
    assign prod_hi = r_prod[2*N-1:N];

endmodule

// File: tb/tb_moltiplicatore_seq.sv
// Self-checking bench for moltiplicatore_seq: a vector table of operand
// pairs plus hand-written sequences for the ignored start, back-to-back
// operation and asynchronous reset. Expected products are queued when an
// operation is launched and compared when done pulses.
module tb_moltiplicatore_seq;

    localparam int N = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] prod_lo;
    logic [N-1:0] prod_hi;

    int checks   = 0;
    int failures = 0;

    logic [2*N-1:0] sb[$];
    logic [2*N-1:0] sb_exp;
    logic [N-1:0]   r_ds_reg;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] exp;
        string          name;
    } vec_t;

    vec_t vecs[7];

    moltiplicatore_seq #(.N(N)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .prod_lo (prod_lo),
        .prod_hi (prod_hi)
    );

    always #5 clock = ~clock;

    // Downstream write-enabled register: prod_lo is written on the edge that ends the done cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_ds_reg <= '0;
        else if (done) r_ds_reg <= prod_lo;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expected product.
    always @(negedge clock) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: done=1 with no operation outstanding, product 0x%0h", {prod_hi, prod_lo});
            end else begin
                sb_exp = sb.pop_front();
                check("product", {prod_hi, prod_lo}, sb_exp);
            end
        end
    end

    // Waits (bounded) for done, measuring edges since the accepting edge and busy cycles.
    // Called at a negedge just after start was raised; optionally pulses a 9*9 start at edge poke_at.
    task automatic wait_done(input string name, input bit hold, input int poke_at, output int lat);
        int  edges  = 0;
        int  busy_n = 0;
        bit  seen   = 1'b0;
        while (!seen && edges < 200) begin
            @(negedge clock);
            edges++;
            if (edges == 1 && !hold) start = 1'b0;
            if (poke_at > 0 && edges == poke_at) begin
                a = 32'd9;
                b = 32'd9;
                start = 1'b1;
            end
            if (poke_at > 0 && edges == poke_at + 1) start = 1'b0;
            if (busy) busy_n++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no done after %0d edges, expected within 33", name, edges);
        end
        lat = edges - 1;
        check({name, "_latency"}, 64'(lat), 64'd32);
        check({name, "_busy_cycles"}, 64'(busy_n), 64'd32);
    endtask

    // One complete operation from IDLE, including the done-width and downstream register checks.
    task automatic run_op(input logic [N-1:0] va, input logic [N-1:0] vb,
                          input logic [2*N-1:0] exp, input string name, input int poke_at);
        int lat;
        a = va;
        b = vb;
        start = 1'b1;
        sb.push_back(exp);
        wait_done(name, 1'b0, poke_at, lat);
        @(negedge clock);
        check({name, "_done_one_cycle"}, 64'(done), 64'd0);
        check({name, "_ds_reg"}, 64'(r_ds_reg), 64'(exp[N-1:0]));
    endtask

    initial begin
        int lat1;
        int lat2;
        int extra;

        vecs[0] = '{32'd7,        32'd6,        64'd42,                  "mul_7x6"};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001,  "mul_max"};
        vecs[2] = '{32'h80000000, 32'd2,        64'h00000001_00000000,  "mul_msb_x2"};
        vecs[3] = '{32'h12345678, 32'd0,        64'd0,                   "mul_b_zero"};
        vecs[4] = '{32'd0,        32'hDEADBEEF, 64'd0,                   "mul_a_zero"};
        vecs[5] = '{32'h0000FFFF, 32'h0000FFFF, 64'h00000000_FFFE0001,  "mul_16bit_max"};
        vecs[6] = '{32'h00010000, 32'h00010000, 64'h00000001_00000000,  "mul_2p16_sq"};

        // Reset state.
        #2 reset = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_prod_lo", 64'(prod_lo), 64'd0);
        check("rst_prod_hi", 64'(prod_hi), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Table-driven products.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, 0);
        end

        // start during RUN is ignored: only 3*5 completes.
        run_op(32'd3, 32'd5, 64'd15, "ignore_start", 5);
        extra = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) extra++;
        end
        check("ignore_start_no_extra_done", 64'(extra), 64'd0);

        // Back-to-back: start held, operands switched in the DONE cycle.
        a = 32'd3;
        b = 32'd5;
        start = 1'b1;
        sb.push_back(64'd15);
        wait_done("b2b_first", 1'b1, 0, lat1);
        a = 32'd4;
        b = 32'd4;
        sb.push_back(64'd16);
        wait_done("b2b_second", 1'b1, 0, lat2);
        start = 1'b0;
        check("b2b_second_done_edge", 64'(lat1 + 1 + lat2), 64'd65);
        @(negedge clock);
        check("b2b_done_one_cycle", 64'(done), 64'd0);
        check("b2b_ds_reg", 64'(r_ds_reg), 64'd16);

        // Asynchronous reset mid-RUN, then release with start already high.
        a = 32'd7;
        b = 32'd6;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        check("abort_busy_before", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_prod", 64'({prod_hi, prod_lo}), 64'd0);
        a = 32'd2;
        b = 32'd2;
        start = 1'b1;
        @(negedge clock);
        sb.push_back(64'd4);
        reset = 1'b0;
        wait_done("post_reset", 1'b0, 0, lat1);
        @(negedge clock);
        check("post_reset_done_one_cycle", 64'(done), 64'd0);
        check("post_reset_ds_reg", 64'(r_ds_reg), 64'd4);
        extra = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) extra++;
        end
        check("post_reset_no_extra_done", 64'(extra), 64'd0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
